video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
//==============================================================================
// video_timing_gen
// Raster timing generator: horizontal/vertical counters, blanking, sync,
// display-enable, blanked pixel pass-through, frame/line events and a field
// toggle. Configuration is shadowed and only takes effect at frame wrap.
// Rev 1.0
//==============================================================================
`default_nettype none

module video_timing_gen #(
   parameter int   HW     = 9,
   parameter int   VW     = 9,
   parameter int   RGBW   = 12,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic            ce_pix,
   input  logic [HW-1:0]   h_total,
   input  logic [HW-1:0]   h_active,
   input  logic [HW-1:0]   hs_start,
   input  logic [HW-1:0]   hs_end,
   input  logic [VW-1:0]   v_total,
   input  logic [VW-1:0]   v_active,
   input  logic [VW-1:0]   vs_start,
   input  logic [VW-1:0]   vs_end,
   input  logic [VW-1:0]   irq_line,
   input  logic [RGBW-1:0] rgb_in,
   output logic [HW-1:0]   hpos,
   output logic [VW-1:0]   vpos,
   output logic            hblank,
   output logic            vblank,
   output logic            hsync,
   output logic            vsync,
   output logic            de,
   output logic [RGBW-1:0] rgb_out,
   output logic            frame_start,
   output logic            line_irq,
   output logic            field
);

   // Shadow copies of the configuration, stable for a whole frame
   logic [HW-1:0]   h_total_q, h_active_q, hs_start_q, hs_end_q;
   logic [VW-1:0]   v_total_q, v_active_q, vs_start_q, vs_end_q, irq_line_q;

   // Raster counters and registered outputs
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic [VW-1:0]   vcnt_q, vcnt_d;
   logic            hblank_q, hblank_d;
   logic            vblank_q, vblank_d;
   logic            hsync_q, hsync_d;
   logic            vsync_q, vsync_d;
   logic            de_q, de_d;
   logic [RGBW-1:0] rgb_q, rgb_d;
   logic            frame_start_q, frame_start_d;
   logic            line_irq_q, line_irq_d;
   logic            field_q, field_d;

   // Decode helpers
   logic [HW-1:0]   h_last;
   logic [VW-1:0]   v_last;
   logic            h_wrap;
   logic            v_wrap;
   logic            frame_wrap;
   logic            irq_in_range;

   // Next-state computation for counters, flags and events (shadow values only)
   always_comb begin
      // A total of 0 subtracts to all-ones, giving the full counter range
      h_last        = h_total_q - HW'(1);
      v_last        = v_total_q - VW'(1);
      h_wrap        = (hcnt_q >= h_last);
      v_wrap        = (vcnt_q >= v_last);
      frame_wrap    = h_wrap & v_wrap;

      hcnt_d        = h_wrap ? '0 : (hcnt_q + HW'(1));
      vcnt_d        = vcnt_q;
      if (h_wrap) begin
         vcnt_d     = v_wrap ? '0 : (vcnt_q + VW'(1));
      end

      // Flags describe the position the counters are moving to
      hblank_d      = (hcnt_d >= h_active_q);
      vblank_d      = (vcnt_d >= v_active_q);
      hsync_d       = ((hcnt_d >= hs_start_q) && (hcnt_d < hs_end_q)) ? HS_POL : ~HS_POL;
      vsync_d       = ((vcnt_d >= vs_start_q) && (vcnt_d < vs_end_q)) ? VS_POL : ~VS_POL;
      de_d          = ~hblank_d & ~vblank_d;

      // Pixel data is gated by the flags of the position being left,
      // which lines rgb_out up one pixel behind hpos
      rgb_d         = (hblank_q | vblank_q) ? '0 : rgb_in;

      frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
      irq_in_range  = (irq_line_q <= v_last);
      line_irq_d    = h_wrap && (vcnt_d == irq_line_q) && irq_in_range;

      field_d       = frame_wrap ? ~field_q : field_q;
   end

   // Shadow configuration: captured at reset and at each frame wrap
   always_ff @(posedge clk_sys) begin
      if (reset || (ce_pix && frame_wrap)) begin
         h_total_q  <= h_total;
         h_active_q <= h_active;
         hs_start_q <= hs_start;
         hs_end_q   <= hs_end;
         v_total_q  <= v_total;
         v_active_q <= v_active;
         vs_start_q <= vs_start;
         vs_end_q   <= vs_end;
         irq_line_q <= irq_line;
      end
   end

   // Counters: reset parks them on the last position so the first pixel is (0,0)
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hcnt_q <= h_total - HW'(1);
         vcnt_q <= v_total - VW'(1);
      end else if (ce_pix) begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   // Timing flags, pixel data and field: update once per pixel, hold otherwise
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
         hsync_q  <= ~HS_POL;
         vsync_q  <= ~VS_POL;
         de_q     <= 1'b0;
         rgb_q    <= '0;
         field_q  <= 1'b0;
      end else if (ce_pix) begin
         hblank_q <= hblank_d;
         vblank_q <= vblank_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         de_q     <= de_d;
         rgb_q    <= rgb_d;
         field_q  <= field_d;
      end
   end

   // Event pulses: single clk_sys wide, cleared on every non-pixel cycle
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         frame_start_q <= 1'b0;
         line_irq_q    <= 1'b0;
      end else if (ce_pix) begin
         frame_start_q <= frame_start_d;
         line_irq_q    <= line_irq_d;
      end else begin
         frame_start_q <= 1'b0;
         line_irq_q    <= 1'b0;
      end
   end

   assign hpos        = hcnt_q;
   assign vpos        = vcnt_q;
   assign hblank      = hblank_q;
   assign vblank      = vblank_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rgb_out     = rgb_q;
   assign frame_start = frame_start_q;
   assign line_irq    = line_irq_q;
   assign field       = field_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
//==============================================================================
// tb_video_timing_gen
// Directed frame sequences for video_timing_gen. Each issued pixel pushes its
// expected output tuple into a queue; a monitor pops and compares after every
// pixel/reset edge and checks that outputs hold between enables.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_video_timing_gen;

   localparam int   HW     = 9;
   localparam int   VW     = 9;
   localparam int   RGBW   = 12;
   localparam logic HS_POL = 1'b0;
   localparam logic VS_POL = 1'b0;

   logic            clk_sys = 1'b0;
   logic            reset   = 1'b0;
   logic            ce_pix  = 1'b0;
   logic [HW-1:0]   h_total, h_active, hs_start, hs_end;
   logic [VW-1:0]   v_total, v_active, vs_start, vs_end, irq_line;
   logic [RGBW-1:0] rgb_in  = '0;
   logic [HW-1:0]   hpos;
   logic [VW-1:0]   vpos;
   logic            hblank, vblank, hsync, vsync, de;
   logic [RGBW-1:0] rgb_out;
   logic            frame_start, line_irq, field;

   typedef struct packed {
      logic [HW-1:0]   hpos;
      logic [VW-1:0]   vpos;
      logic            hb;
      logic            vb;
      logic            hs;
      logic            vs;
      logic            de;
      logic [RGBW-1:0] rgb;
      logic            fs;
      logic            li;
      logic            fld;
   } exp_t;

   typedef struct {
      int ht, ha, hss, hse, vt, va, vss, vse, irq;
   } cfg_t;

   exp_t  expq[$];
   string tagq[$];
   int    n_vec  = 0;
   int    n_miss = 0;

   cfg_t  cur;
   cfg_t  shadow_m;
   bit    prev_active;
   bit    field_m;
   exp_t  last_exp;
   bit    have_last = 1'b0;

   video_timing_gen #(
      .HW(HW), .VW(VW), .RGBW(RGBW), .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
      .h_total(h_total), .h_active(h_active), .hs_start(hs_start), .hs_end(hs_end),
      .v_total(v_total), .v_active(v_active), .vs_start(vs_start), .vs_end(vs_end),
      .irq_line(irq_line), .rgb_in(rgb_in),
      .hpos(hpos), .vpos(vpos), .hblank(hblank), .vblank(vblank),
      .hsync(hsync), .vsync(vsync), .de(de), .rgb_out(rgb_out),
      .frame_start(frame_start), .line_irq(line_irq), .field(field)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic int eff(input int t, input int w);
      return (t == 0) ? (1 << w) : t;
   endfunction

   function automatic void check(input string tg, input exp_t a, input exp_t e);
      n_vec++;
      if (a !== e) begin
         n_miss++;
         $display("FAIL %s: got h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b de=%b rgb=%h fs=%b li=%b fld=%b, want h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b de=%b rgb=%h fs=%b li=%b fld=%b",
                  tg, a.hpos, a.vpos, a.hb, a.vb, a.hs, a.vs, a.de, a.rgb, a.fs, a.li, a.fld,
                  e.hpos, e.vpos, e.hb, e.vb, e.hs, e.vs, e.de, e.rgb, e.fs, e.li, e.fld);
      end
   endfunction

   task automatic drive_cfg();
      h_total  = HW'(cur.ht);
      h_active = HW'(cur.ha);
      hs_start = HW'(cur.hss);
      hs_end   = HW'(cur.hse);
      v_total  = VW'(cur.vt);
      v_active = VW'(cur.va);
      vs_start = VW'(cur.vss);
      vs_end   = VW'(cur.vse);
      irq_line = VW'(cur.irq);
   endtask

   // One pixel enable; the expectation is queued before the edge it describes
   task automatic pix(input exp_t e, input string tg, input int gap);
      ce_pix = 1'b1;
      expq.push_back(e);
      tagq.push_back(tg);
      @(posedge clk_sys); #1;
      ce_pix = 1'b0;
      repeat (gap) begin
         @(posedge clk_sys); #1;
      end
   endtask

   // Reset for n cycles; ce_pix is also high on the first one to show priority
   task automatic do_reset(input int cycles);
      exp_t e;
      drive_cfg();
      e      = '0;
      e.hpos = HW'(eff(cur.ht, HW) - 1);
      e.vpos = VW'(eff(cur.vt, VW) - 1);
      e.hb   = 1'b1;
      e.vb   = 1'b1;
      e.hs   = ~HS_POL;
      e.vs   = ~VS_POL;
      for (int i = 0; i < cycles; i++) begin
         reset  = 1'b1;
         ce_pix = (i == 0);
         expq.push_back(e);
         tagq.push_back("reset");
         @(posedge clk_sys); #1;
      end
      reset       = 1'b0;
      ce_pix      = 1'b0;
      shadow_m    = cur;
      prev_active = 1'b0;
      field_m     = 1'b0;
   endtask

   // Walk one frame pixel by pixel; optionally stop early or change h_total mid-frame
   task automatic run_frame(input int stop_v, input int stop_h, input int chg_line,
                            input int new_ht, input bit rnd_rgb, input int gap,
                            input string tg);
      cfg_t fc;
      cfg_t c;
      int   hn, vn;
      exp_t e;
      fc = cur;
      hn = eff(fc.ht, HW);
      vn = eff(fc.vt, VW);
      for (int v = 0; v < vn; v++) begin
         for (int h = 0; h < hn; h++) begin
            if (v == stop_v && h == stop_h) return;
            if (v == chg_line && h == 0) begin
               cur.ht = new_ht;
               drive_cfg();
            end
            // the frame-entry pixel is still judged with the previous frame's settings
            c      = (h == 0 && v == 0) ? shadow_m : fc;
            rgb_in = rnd_rgb ? RGBW'($urandom) : RGBW'(12'hABC);
            e.hpos = HW'(h);
            e.vpos = VW'(v);
            e.hb   = (h >= c.ha);
            e.vb   = (v >= c.va);
            e.hs   = (h >= c.hss && h < c.hse) ? HS_POL : ~HS_POL;
            e.vs   = (v >= c.vss && v < c.vse) ? VS_POL : ~VS_POL;
            e.de   = !e.hb && !e.vb;
            e.rgb  = prev_active ? rgb_in : '0;
            e.fs   = (h == 0 && v == 0);
            e.li   = (h == 0 && v == c.irq && c.irq < eff(c.vt, VW));
            if (e.fs) field_m = ~field_m;
            e.fld  = field_m;
            prev_active = e.de;
            if (e.fs) shadow_m = fc;
            pix(e, tg, gap);
         end
      end
   endtask

   // Monitor: compare after every pixel/reset edge, check holding otherwise
   initial begin
      exp_t  act;
      exp_t  ex;
      bit    ev;
      string tg;
      forever begin
         @(posedge clk_sys);
         ev = reset || ce_pix;
         @(negedge clk_sys);
         act.hpos = hpos;    act.vpos = vpos;
         act.hb   = hblank;  act.vb   = vblank;
         act.hs   = hsync;   act.vs   = vsync;
         act.de   = de;      act.rgb  = rgb_out;
         act.fs   = frame_start;
         act.li   = line_irq;
         act.fld  = field;
         if (ev) begin
            if (expq.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_output: got %h with nothing expected", act);
            end else begin
               ex = expq.pop_front();
               tg = tagq.pop_front();
               check(tg, act, ex);
               last_exp    = ex;
               last_exp.fs = 1'b0;
               last_exp.li = 1'b0;
               have_last   = 1'b1;
            end
         end else if (have_last) begin
            check("hold", act, last_exp);
         end
      end
   end

   // Watchdog: the run is bounded even if something stalls
   initial begin
      #2_000_000;
      n_vec++;
      n_miss++;
      $display("FAIL watchdog: got time limit reached, want completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      // default timing, first lines only (full 263-line frame is too long here)
      cur = '{384, 288, 311, 343, 263, 224, 226, 234, 100};
      drive_cfg();
      repeat (2) @(posedge clk_sys);
      #1;
      do_reset(2);
      run_frame(3, 0, -1, 0, 1'b0, 0, "default_lines");

      // full frames at 384 wide; h_total goes to 400 on line 2, seen next frame
      cur = '{384, 288, 311, 343, 5, 3, 3, 4, 1};
      do_reset(1);
      run_frame(-1, -1, 2, 400, 1'b0, 0, "htotal_old");
      run_frame(-1, -1, -1, 0, 1'b0, 0, "htotal_new");
      run_frame(1, 5, -1, 0, 1'b0, 0, "htotal_next");

      // line interrupt on line 100, random pixel data
      cur = '{10, 6, 7, 9, 120, 100, 110, 112, 100};
      do_reset(1);
      run_frame(-1, -1, -1, 0, 1'b1, 0, "irq100_f0");
      run_frame(-1, -1, -1, 0, 1'b1, 0, "irq100_f1");

      // irq line beyond the frame never fires; inverted vsync window stays inactive
      cur = '{10, 6, 7, 9, 120, 100, 112, 110, 300};
      do_reset(1);
      run_frame(-1, -1, -1, 0, 1'b1, 0, "irq300");

      // pixel enable every 4th clock, outputs must hold between enables
      cur = '{12, 9, 9, 11, 6, 4, 4, 5, 3};
      do_reset(1);
      run_frame(-1, -1, -1, 0, 1'b1, 3, "ce_div4_f0");
      run_frame(-1, -1, -1, 0, 1'b1, 3, "ce_div4_f1");

      // reset in the middle of line 150 abandons the frame
      cur = '{8, 6, 6, 7, 200, 180, 185, 190, 150};
      do_reset(1);
      run_frame(150, 5, -1, 0, 1'b1, 0, "pre_reset");
      do_reset(1);
      run_frame(2, 0, -1, 0, 1'b1, 0, "post_reset");

      // zero totals: horizontal counter uses its full range
      cur = '{0, 500, 505, 510, 2, 1, 1, 2, 1};
      do_reset(1);
      run_frame(-1, -1, -1, 0, 1'b1, 0, "htotal_zero");
      run_frame(0, 3, -1, 0, 1'b1, 0, "htotal_zero_wrap");

      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      n_vec++;
      if (expq.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
